// File: rtl/writeback_stage_p_if.sv
// Bus bundle for writeback_stage_p: MEM/WB handshake, register-file write port and
// the two forwarding query ports.
interface writeback_stage_p_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_pc;
    logic [WIDTH-1:0]    in_mem_out;
    logic [WIDTH-1:0]    in_alu_out;
    logic [REG_BITS-1:0] in_rf_dest;
    logic [5:0]          in_opcode;
    logic [1:0]          in_addr_lo;
    logic                wb_stall;
    logic                rf_write;
    logic [REG_BITS-1:0] rf_dest;
    logic [WIDTH-1:0]    rf_data;
    logic [REG_BITS-1:0] q0_reg;
    logic [REG_BITS-1:0] q1_reg;
    logic                q0_hit;
    logic                q1_hit;
    logic [WIDTH-1:0]    q0_data;
    logic [WIDTH-1:0]    q1_data;

    modport master (
        output in_valid, in_pc, in_mem_out, in_alu_out, in_rf_dest, in_opcode, in_addr_lo,
        output wb_stall, q0_reg, q1_reg,
        input  in_ready, rf_write, rf_dest, rf_data, q0_hit, q1_hit, q0_data, q1_data
    );

    modport slave (
        input  in_valid, in_pc, in_mem_out, in_alu_out, in_rf_dest, in_opcode, in_addr_lo,
        input  wb_stall, q0_reg, q1_reg,
        output in_ready, rf_write, rf_dest, rf_data, q0_hit, q1_hit, q0_data, q1_data
    );
endinterface

// File: rtl/writeback_stage_p.sv
// Registered MIPS write-back stage with retired-write history and two forwarding ports.
// Define WB_SUBWORD_LOAD_EN to enable lb/lbu/lh/lhu lane extraction and extension.
module writeback_stage_p #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LINK_REG = 31
) (
    input logic               clk,
    input logic               rst,
    writeback_stage_p_if.slave bus
);
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;
    localparam logic [5:0] OpBltz = 6'h01;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpBlez = 6'h06;
    localparam logic [5:0] OpBgtz = 6'h07;
    localparam logic [5:0] OpLb   = 6'h20;
    localparam logic [5:0] OpLh   = 6'h21;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpLbu  = 6'h24;
    localparam logic [5:0] OpLhu  = 6'h25;
    localparam logic [5:0] OpSb   = 6'h28;
    localparam logic [5:0] OpSh   = 6'h29;
    localparam logic [5:0] OpSw   = 6'h2B;

    logic                slot_valid_q, slot_we_q;
    logic [REG_BITS-1:0] slot_dest_q;
    logic [WIDTH-1:0]    slot_data_q;

    logic                hist_valid_q [DEPTH];
    logic [REG_BITS-1:0] hist_dest_q  [DEPTH];
    logic [WIDTH-1:0]    hist_data_q  [DEPTH];

    logic                dec_we;
    logic [REG_BITS-1:0] dec_dest;
    logic [WIDTH-1:0]    dec_data;
    logic [WIDTH-1:0]    load_data;
    logic [WIDTH:0]      q0_res, q1_res;

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Big-endian lanes: addr_lo 0 addresses the most significant byte.
    always_comb begin
        ld_byte = '0;
        unique case (bus.in_addr_lo)
            2'd0: ld_byte = bus.in_mem_out[31:24];
            2'd1: ld_byte = bus.in_mem_out[23:16];
            2'd2: ld_byte = bus.in_mem_out[15:8];
            2'd3: ld_byte = bus.in_mem_out[7:0];
        endcase
        ld_half = bus.in_addr_lo[1] ? bus.in_mem_out[15:0] : bus.in_mem_out[31:16];
        case (bus.in_opcode)
            OpLb:    load_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            OpLbu:   load_data = {{(WIDTH-8){1'b0}}, ld_byte};
            OpLh:    load_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
            OpLhu:   load_data = {{(WIDTH-16){1'b0}}, ld_half};
            default: load_data = bus.in_mem_out;
        endcase
    end
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.in_addr_lo;
    assign load_data      = bus.in_mem_out;
`endif

    always_comb begin
        dec_we   = 1'b1;
        dec_dest = bus.in_rf_dest;
        dec_data = bus.in_alu_out;
        case (bus.in_opcode)
            OpJ, OpBltz, OpBeq, OpBne, OpBlez, OpBgtz, OpSb, OpSh, OpSw: dec_we = 1'b0;
            OpJal: begin
                dec_dest = REG_BITS'(LINK_REG);
                dec_data = bus.in_pc + WIDTH'(8);
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu: dec_data = load_data;
            default: ;
        endcase
        if (dec_dest == '0) dec_we = 1'b0;
    end

    assign bus.in_ready = ~bus.wb_stall;
    assign bus.rf_write = slot_valid_q & slot_we_q & ~bus.wb_stall;
    assign bus.rf_dest  = slot_dest_q;
    assign bus.rf_data  = slot_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_dest_q  <= '0;
            slot_data_q  <= '0;
        end else if (bus.in_ready) begin
            slot_valid_q <= bus.in_valid;
            slot_we_q    <= bus.in_valid & dec_we;
            slot_dest_q  <= dec_dest;
            slot_data_q  <= dec_data;
        end
    end

    // Entry 0 is the newest retired write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_valid_q[i] <= 1'b0;
                hist_dest_q[i]  <= '0;
                hist_data_q[i]  <= '0;
            end
        end else if (bus.rf_write) begin
            hist_valid_q[0] <= 1'b1;
            hist_dest_q[0]  <= slot_dest_q;
            hist_data_q[0]  <= slot_data_q;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_valid_q[i] <= hist_valid_q[i-1];
                hist_dest_q[i]  <= hist_dest_q[i-1];
                hist_data_q[i]  <= hist_data_q[i-1];
            end
        end
    end

    // Later assignments win: oldest history first, then newer, then the slot.
    function automatic logic [WIDTH:0] lookup(input logic [REG_BITS-1:0] q);
        logic [WIDTH:0] r;
        r = '0;
        if (q != '0) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (hist_valid_q[i] && hist_dest_q[i] == q) r = {1'b1, hist_data_q[i]};
            end
            if (slot_valid_q && slot_we_q && slot_dest_q == q) r = {1'b1, slot_data_q};
        end
        return r;
    endfunction

    always_comb begin
        q0_res = lookup(bus.q0_reg);
        q1_res = lookup(bus.q1_reg);
    end

    assign bus.q0_hit  = q0_res[WIDTH];
    assign bus.q0_data = q0_res[WIDTH-1:0];
    assign bus.q1_hit  = q1_res[WIDTH];
    assign bus.q1_data = q1_res[WIDTH-1:0];
endmodule

// File: tb/tb_writeback_stage_p.sv
// Self-checking bench for writeback_stage_p: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_writeback_stage_p;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned REG_BITS = 5;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned LINK_REG = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;

    writeback_stage_p_if #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) bus ();

    writeback_stage_p #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .LINK_REG(LINK_REG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Reference model: pending slot plus retired writes, newest at the front.
    bit          m_valid, m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_data;
    logic [4:0]  h_dest[$];
    logic [31:0] h_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_reset();
        m_valid = 0; m_we = 0; m_dest = '0; m_data = '0;
        h_dest.delete(); h_data.delete();
    endfunction

    function automatic void ref_decode(input logic [5:0] op, input logic [31:0] pc,
                                       input logic [31:0] mem, input logic [31:0] alu,
                                       input logic [4:0] dst, input logic [1:0] lo,
                                       output bit we, output logic [4:0] d,
                                       output logic [31:0] data);
        logic [31:0] b, h;
        b = (mem >> (8 * (3 - int'(lo)))) & 32'hFF;
        h = (mem >> (16 * (1 - int'(lo[1])))) & 32'hFFFF;
        d = dst; data = alu; we = 1;
        if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h29, 6'h2B, 6'h02}) we = 0;
        if (op == 6'h03) begin d = 5'd31; data = pc + 32'd8; end
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            data = mem;
`ifdef WB_SUBWORD_LOAD_EN
            if (op == 6'h24) data = b;
            if (op == 6'h25) data = h;
            if (op == 6'h20) data = b[7]  ? (b | 32'hFFFFFF00) : b;
            if (op == 6'h21) data = h[15] ? (h | 32'hFFFF0000) : h;
`endif
        end
        if (d == 5'd0) we = 0;
    endfunction

    function automatic void ref_fwd(input logic [4:0] q, output logic hit, output logic [31:0] d);
        hit = 0; d = '0;
        if (q == 5'd0) return;
        if (m_valid && m_we && m_dest == q) begin hit = 1; d = m_data; return; end
        foreach (h_dest[i]) begin
            if (h_dest[i] == q) begin hit = 1; d = h_data[i]; return; end
        end
    endfunction

    task automatic check_outputs();
        logic        exp_wr, hit;
        logic [31:0] d;
        exp_wr = m_valid && m_we && !bus.wb_stall;
        chk("in_ready", 32'(bus.in_ready), 32'(!bus.wb_stall));
        chk("rf_write", 32'(bus.rf_write), 32'(exp_wr));
        if (exp_wr) begin
            chk("rf_dest", 32'(bus.rf_dest), 32'(m_dest));
            chk("rf_data", bus.rf_data, m_data);
        end
        ref_fwd(bus.q0_reg, hit, d);
        chk("q0_hit", 32'(bus.q0_hit), 32'(hit));
        chk("q0_data", bus.q0_data, d);
        ref_fwd(bus.q1_reg, hit, d);
        chk("q1_hit", 32'(bus.q1_hit), 32'(hit));
        chk("q1_data", bus.q1_data, d);
        if (bus.rf_write) pulses++;
    endtask

    task automatic model_edge();
        if (m_valid && m_we && !bus.wb_stall) begin
            h_dest.push_front(m_dest);
            h_data.push_front(m_data);
            if (h_dest.size() > int'(DEPTH)) begin
                void'(h_dest.pop_back());
                void'(h_data.pop_back());
            end
        end
        if (!bus.wb_stall) begin
            m_valid = bus.in_valid;
            if (bus.in_valid)
                ref_decode(bus.in_opcode, bus.in_pc, bus.in_mem_out, bus.in_alu_out,
                           bus.in_rf_dest, bus.in_addr_lo, m_we, m_dest, m_data);
            else
                m_we = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        tick();
        clk_edge();
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [31:0] pc,
                         input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] dst,
                         input logic [1:0] lo, input bit stall);
        bus.in_valid = v; bus.in_opcode = op; bus.in_pc = pc; bus.in_mem_out = mem;
        bus.in_alu_out = alu; bus.in_rf_dest = dst; bus.in_addr_lo = lo; bus.wb_stall = stall;
    endtask

    task automatic set_q(input logic [4:0] a, input logic [4:0] b);
        bus.q0_reg = a; bus.q1_reg = b;
    endtask

    task automatic bubble(input bit stall);
        drive(0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, stall);
    endtask

    // Issue one instruction, then check what retires on the following cycle.
    task automatic issue_see(input string tag, input logic [5:0] op, input logic [31:0] pc,
                             input logic [31:0] mem, input logic [31:0] alu,
                             input logic [4:0] dst, input logic [1:0] lo, input bit exp_wr,
                             input logic [4:0] exp_dest, input logic [31:0] exp_data);
        drive(1, op, pc, mem, alu, dst, lo, 0);
        set_q(dst, exp_dest);
        step();
        bubble(0);
        tick();
        chk({tag, "_wr"}, 32'(bus.rf_write), 32'(exp_wr));
        if (exp_wr) begin
            chk({tag, "_dest"}, 32'(bus.rf_dest), 32'(exp_dest));
            chk({tag, "_data"}, bus.rf_data, exp_data);
        end
        clk_edge();
    endtask

    localparam logic [31:0] LbExp  = `ifdef WB_SUBWORD_LOAD_EN 32'hFFFFFF83 `else 32'h11228344 `endif;
    localparam logic [31:0] LhuExp = `ifdef WB_SUBWORD_LOAD_EN 32'h00001122 `else 32'h11228344 `endif;
    localparam logic [31:0] LbuExp = `ifdef WB_SUBWORD_LOAD_EN 32'h00000044 `else 32'h11228344 `endif;

    logic [5:0] ops [14] = '{6'h09, 6'h00, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h21, 6'h25,
                             6'h03, 6'h02, 6'h04, 6'h05, 6'h2B, 6'h28};

    initial begin
        bubble(0);
        set_q(5'd5, 5'd0);
        ref_reset();
        #2;
        chk("rst_wr", 32'(bus.rf_write), 32'd0);
        chk("rst_dest", 32'(bus.rf_dest), 32'd0);
        chk("rst_data", bus.rf_data, 32'd0);
        chk("rst_q0", 32'(bus.q0_hit), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic ALU write and its history entry.
        issue_see("addiu", 6'h09, 32'h0, 32'h0, 32'h1234, 5'd8, 2'd0, 1, 5'd8, 32'h1234);
        set_q(5'd8, 5'd0);
        tick();
        chk("hist_q0_hit", 32'(bus.q0_hit), 32'd1);
        chk("hist_q0_data", bus.q0_data, 32'h1234);
        clk_edge();

        issue_see("lb", 6'h20, 32'h0, 32'h11228344, 32'h0, 5'd10, 2'd2, 1, 5'd10, LbExp);
        issue_see("lhu", 6'h25, 32'h0, 32'h11228344, 32'h0, 5'd11, 2'd0, 1, 5'd11, LhuExp);
        issue_see("lbu", 6'h24, 32'h0, 32'h11228344, 32'h0, 5'd12, 2'd3, 1, 5'd12, LbuExp);
        issue_see("jal", 6'h03, 32'h00400010, 32'h0, 32'h0, 5'd0, 2'd0, 1, 5'd31, 32'h00400018);
        issue_see("sw", 6'h2B, 32'h0, 32'h0, 32'hDEAD, 5'd13, 2'd0, 0, 5'd13, 32'h0);
        issue_see("beq", 6'h04, 32'h0, 32'h0, 32'hBEEF, 5'd14, 2'd0, 0, 5'd14, 32'h0);
        issue_see("j", 6'h02, 32'h0, 32'h0, 32'hF00D, 5'd15, 2'd0, 0, 5'd15, 32'h0);

        // Stall: slot held, forwarded, then exactly one retire.
        drive(1, 6'h23, 32'h0, 32'hCAFEF00D, 32'h0, 5'd9, 2'd0, 0);
        set_q(5'd9, 5'd3);
        step();
        drive(1, 6'h09, 32'h0, 32'h0, 32'h777, 5'd3, 2'd0, 1);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rdy", 32'(bus.in_ready), 32'd0);
            chk("stall_wr", 32'(bus.rf_write), 32'd0);
            chk("stall_q0", bus.q0_data, 32'hCAFEF00D);
            clk_edge();
        end
        bubble(0);
        step();
        step();
        chk("stall_pulses", 32'(pulses), 32'd1);
        tick();
        chk("stall_hist_q0", bus.q0_data, 32'hCAFEF00D);
        chk("stall_q1_miss", 32'(bus.q1_hit), 32'd0);
        clk_edge();

        // History ordering and eviction with DEPTH=2.
        set_q(5'd5, 5'd5);
        drive(1, 6'h09, 32'h0, 32'h0, 32'd1, 5'd5, 2'd0, 0); step();
        drive(1, 6'h09, 32'h0, 32'h0, 32'd2, 5'd5, 2'd0, 0); step();
        drive(1, 6'h09, 32'h0, 32'h0, 32'd3, 5'd6, 2'd0, 0); step();
        bubble(0); step();
        tick();
        chk("hist_newest_hit", 32'(bus.q0_hit), 32'd1);
        chk("hist_newest_data", bus.q0_data, 32'd2);
        clk_edge();
        drive(1, 6'h09, 32'h0, 32'h0, 32'd4, 5'd7, 2'd0, 0); step();
        bubble(0); step();
        tick();
        chk("evict_q1_hit", 32'(bus.q1_hit), 32'd0);
        chk("evict_q1_data", bus.q1_data, 32'd0);
        clk_edge();

        // Reset while a write is pending behind a stall.
        drive(1, 6'h09, 32'h0, 32'h0, 32'h55, 5'd11, 2'd0, 0);
        set_q(5'd11, 5'd11);
        step();
        bubble(1);
        tick();
        #1 rst = 1'b1;
        ref_reset();
        #1;
        chk("rstmid_wr", 32'(bus.rf_write), 32'd0);
        chk("rstmid_q0", 32'(bus.q0_hit), 32'd0);
        chk("rstmid_dest", 32'(bus.rf_dest), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bubble(0);
        pulses = 0;
        step();
        step();
        chk("rstmid_pulses", 32'(pulses), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), ops[$urandom_range(0, 13)], $urandom,
                  $urandom, $urandom, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
            set_q(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/writeback_stage_p.md
Name: writeback_stage_p

Overview:
- Registered, parametrised MIPS write-back stage; sits between the memory stage and the register file.
- Replaces the old purely combinational write-back:
  - adds a MEM/WB pipeline register with valid/stall handshake;
  - decodes opcodes internally, including jal link writes;
  - extracts and extends sub-word loads;
  - keeps a DEPTH-entry retired-write history that answers two forwarding queries per cycle.

Parameters:
- WIDTH, 32, data/pc width in bits.
- REG_BITS, 5, register index width.
- DEPTH, 2, retired-write history entries (1..8).
- LINK_REG, 31, destination written by jal.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  WIDTH  pc of instruction.
- in_mem_out  in  WIDTH  raw memory read word.
- in_alu_out  in  WIDTH  ALU result.
- in_rf_dest  in  REG_BITS  decoded destination.
- in_opcode  in  6  instruction opcode.
- in_addr_lo  in  2  low address bits of load.
- wb_stall  in  1  register file cannot take a write this cycle.
- rf_write  out  1  register-file write strobe.
- rf_dest  out  REG_BITS  write index.
- rf_data  out  WIDTH  write data.
- q0_reg, q1_reg  in  REG_BITS  forwarding query indices.
- q0_hit, q1_hit  out  1  query matched.
- q0_data, q1_data  out  WIDTH  forwarded value.

Behaviour:
- in_ready = !wb_stall; purely combinational, with no dependence on in_valid.
- Slot register (valid, we, dest, data) loads on every clock edge where in_ready=1:
  - in_valid=1: captures the instruction.
  - in_valid=0: loads a bubble (valid=0).
  - wb_stall=1: slot holds its contents.
- Latency: accept at edge N, then rf_write is visible during cycle N+1.
- rf_write = slot.valid & slot.we & !wb_stall. The strobe is suppressed during a stall and fires in the first non-stalled cycle.
- we decode:
  - we=0 for branches (op 1,4,5,6,7), stores (0x28,0x29,0x2B), j (2), and any dest==0.
  - we=1 otherwise.
- Data/dest decode:
  - jal (3): dest=LINK_REG, data=in_pc+8, computed mod 2^WIDTH.
  - Loads (0x20,0x21,0x23,0x24,0x25): data = load-extracted in_mem_out.
  - Everything else: data=in_alu_out.
- Load extraction (big-endian lanes):
  - lb/lbu select byte lane 3-in_addr_lo.
  - lh/lhu select half lane 1-in_addr_lo[1]; in_addr_lo[0] is ignored.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the full word.
- History is a shift buffer of DEPTH entries {valid, dest, data}:
  - Pushes the slot contents when rf_write=1; the oldest entry drops off.
  - No push on a stall or on a non-writing slot.
- Forwarding, per query port, combinational, priority order:
  1. Current slot, if slot.valid & slot.we, regardless of stall.
  2. History, newest to oldest.
  - Query reg 0 never hits.
  - Miss gives hit=0, data=0.
- Reset (async, immediate): slot.valid=0; all history valid=0; rf_write=0; rf_dest=0; rf_data=0; q*_hit=0. in_ready then follows wb_stall.
- Reset mid-stall: the pending write is discarded and never issued.
- Simultaneous accept and retire in one cycle is normal flow: the history push and the slot load happen on the same edge.

Optional Feature:
- Macro: WB_SUBWORD_LOAD_EN.
- Defined: sub-word extraction as above.
- Undefined:
  - All load opcodes write in_mem_out unmodified.
  - in_addr_lo is unused.
  - lb/lbu/lh/lhu are still decoded as writing loads.

Test Plan:
- addiu with alu_out=0x1234, dest=8, no stall → next cycle rf_write=1, rf_dest=8, rf_data=0x1234; history[0]={8,0x1234}.
- lb with mem_out=0x11228344, addr_lo=2 → rf_data=0xFFFFFF83. lhu with addr_lo=0 → 0x00001122. lbu with addr_lo=3 → 0x00000044. (With the macro undefined, all give 0x11228344.)
- jal at pc=0x00400010 → rf_dest=31, rf_data=0x00400018. sw, beq and j each → rf_write=0 and no history push.
- Stall:
  - load slot, then hold wb_stall=1 for 3 cycles → rf_write=0 and in_ready=0 throughout; q0_reg=dest hits with slot data.
  - Release stall → one rf_write pulse and exactly one push.
- DEPTH=2, writes r5=1, r5=2, r6=3 retired back-to-back → q0_reg=5 returns 2, not 1. A further write to r7 evicts r5=2, so a q1_reg=5 query misses.
- Assert rst while the slot is valid and stalled → rf_write=0 immediately. After release, no write is issued and all queries miss.
